// File: rtl/parking_controller.sv
// Entry/exit sequencer for an 8-space lot: allocates spaces, issues XOR tokens,
// decrypts exit tokens and arbitrates simultaneous requests with a toggling priority bit.
module parking_controller #(
    parameter logic [2:0] DEFAULT_PATTERN = 3'b101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pattern_load,
    input  logic [2:0] pattern_in,
    input  logic       enter_req,
    input  logic       exit_req,
    input  logic [2:0] exit_token,
    output logic       enter_ack,
    output logic       enter_reject,
    output logic [2:0] token_out,
    output logic       exit_ack,
    output logic       exit_ok,
    output logic [2:0] park_number,
    output logic [7:0] occupied,
    output logic [3:0] count,
    output logic       full
);

    typedef enum logic [2:0] {
        StIdle,
        StEntrySel,
        StEntryAck,
        StExitDec,
        StExitAck,
        StWaitRel
    } state_e;

    state_e     state_q;
    logic       prio_q;
    logic       serving_exit_q;
    logic [2:0] pattern_q;
    logic [2:0] free_idx;

    // Lowest-index free space; scanning downwards lets the lowest index win.
    always_comb begin
        free_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!occupied[i]) free_idx = 3'(i);
        end
    end

    assign full = (count == 4'd8);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            prio_q         <= 1'b0;
            serving_exit_q <= 1'b0;
            pattern_q      <= DEFAULT_PATTERN;
            occupied       <= 8'h00;
            count          <= 4'd0;
            token_out      <= 3'd0;
            park_number    <= 3'd0;
            enter_ack      <= 1'b0;
            enter_reject   <= 1'b0;
            exit_ack       <= 1'b0;
            exit_ok        <= 1'b0;
        end else begin
            enter_ack    <= 1'b0;
            enter_reject <= 1'b0;
            exit_ack     <= 1'b0;
            exit_ok      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Reloading with spaces occupied would orphan outstanding tokens.
                    if (pattern_load && count == 4'd0) pattern_q <= pattern_in;
                    if (enter_req && exit_req) begin
                        prio_q         <= ~prio_q;
                        serving_exit_q <= ~prio_q;
                        state_q        <= prio_q ? StEntrySel : StExitDec;
                    end else if (enter_req) begin
                        serving_exit_q <= 1'b0;
                        state_q        <= StEntrySel;
                    end else if (exit_req) begin
                        serving_exit_q <= 1'b1;
                        state_q        <= StExitDec;
                    end
                end
                StEntrySel: begin
                    if (!full) park_number <= free_idx;
                    state_q <= StEntryAck;
                end
                StEntryAck: begin
                    if (!full) begin
                        enter_ack             <= 1'b1;
                        token_out             <= park_number ^ pattern_q;
                        occupied[park_number] <= 1'b1;
                        count                 <= count + 4'd1;
                    end else begin
                        enter_reject <= 1'b1;
                    end
                    state_q <= StWaitRel;
                end
                StExitDec: begin
                    park_number <= exit_token ^ pattern_q;
                    state_q     <= StExitAck;
                end
                StExitAck: begin
                    exit_ack <= 1'b1;
                    if (occupied[park_number]) begin
                        exit_ok               <= 1'b1;
                        occupied[park_number] <= 1'b0;
                        count                 <= count - 4'd1;
                    end
                    state_q <= StWaitRel;
                end
                StWaitRel: begin
                    if (serving_exit_q ? !exit_req : !enter_req) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_controller.sv
// Directed bench for parking_controller: allocation, tokens, exits, arbitration,
// pattern loading and reset behaviour against hand-computed values.
module tb_parking_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       pattern_load;
    logic [2:0] pattern_in;
    logic       enter_req;
    logic       exit_req;
    logic [2:0] exit_token;
    logic       enter_ack;
    logic       enter_reject;
    logic [2:0] token_out;
    logic       exit_ack;
    logic       exit_ok;
    logic [2:0] park_number;
    logic [7:0] occupied;
    logic [3:0] count;
    logic       full;

    int checks = 0;
    int errors = 0;
    int n_enter = 0;
    int n_exit = 0;

    logic       cap_ok;
    logic       cap_rej;
    logic [2:0] cap_tok;
    logic [2:0] cap_park;

    parking_controller dut (
        .clk          (clk),
        .reset        (reset),
        .pattern_load (pattern_load),
        .pattern_in   (pattern_in),
        .enter_req    (enter_req),
        .exit_req     (exit_req),
        .exit_token   (exit_token),
        .enter_ack    (enter_ack),
        .enter_reject (enter_reject),
        .token_out    (token_out),
        .exit_ack     (exit_ack),
        .exit_ok      (exit_ok),
        .park_number  (park_number),
        .occupied     (occupied),
        .count        (count),
        .full         (full)
    );

    always #5 clk = ~clk;

    always @(posedge enter_ack) n_enter++;
    always @(posedge exit_ack) n_exit++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        enter_req    = 1'b0;
        exit_req     = 1'b0;
        pattern_load = 1'b0;
        pattern_in   = 3'd0;
        exit_token   = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait (bounded) for the response to an entry (ack/reject) or exit request.
    task automatic wait_ev(input bit is_exit, output int lat);
        bit hit;
        lat = 0;
        hit = 1'b0;
        while (!hit && lat < 20) begin
            @(negedge clk);
            lat++;
            hit = is_exit ? exit_ack : (enter_ack | enter_reject);
        end
        check_eq("served", 32'(hit), 32'd1);
        cap_ok   = exit_ok;
        cap_rej  = enter_reject;
        cap_tok  = token_out;
        cap_park = park_number;
    endtask

    task automatic serve(input bit is_exit, input logic [2:0] tok);
        int lat;
        exit_token = tok;
        if (is_exit) exit_req = 1'b1;
        else enter_req = 1'b1;
        wait_ev(is_exit, lat);
        check_eq("latency", 32'(lat), 32'd3);
        enter_req = 1'b0;
        exit_req  = 1'b0;
        @(negedge clk);
        check_eq("pulse_width", 32'({enter_ack, enter_reject, exit_ack}), 32'd0);
    endtask

    initial begin
        logic [2:0] exp_tok [8];
        int lat;
        int ne;
        int nx;
        exp_tok = '{3'b101, 3'b100, 3'b111, 3'b110, 3'b001, 3'b000, 3'b011, 3'b010};

        // Reset state
        apply_reset();
        check_eq("rst_occupied", 32'(occupied), 32'h00);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_token", 32'(token_out), 32'd0);
        check_eq("rst_park", 32'(park_number), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        @(negedge clk);
        check_eq("rst_no_ack", 32'({enter_ack, enter_reject, exit_ack}), 32'd0);

        // Fill the lot
        for (int i = 0; i < 8; i++) begin
            serve(1'b0, 3'd0);
            check_eq("fill_token", 32'(cap_tok), 32'(exp_tok[i]));
            check_eq("fill_park", 32'(cap_park), 32'(i));
            check_eq("fill_count", 32'(count), 32'(i + 1));
            if (i == 0) check_eq("first_occ", 32'(occupied), 32'h01);
        end
        check_eq("full_occ", 32'(occupied), 32'hFF);
        check_eq("full_flag", 32'(full), 32'd1);

        // Ninth entry rejected
        serve(1'b0, 3'd0);
        check_eq("reject", 32'(cap_rej), 32'd1);
        check_eq("reject_token", 32'(token_out), 32'b010);
        check_eq("reject_count", 32'(count), 32'd8);

        // Exit space 1, then re-enter
        serve(1'b1, 3'b100);
        check_eq("exit_ok", 32'(cap_ok), 32'd1);
        check_eq("exit_park", 32'(cap_park), 32'd1);
        check_eq("exit_occ", 32'(occupied), 32'hFD);
        check_eq("exit_count", 32'(count), 32'd7);
        check_eq("exit_full", 32'(full), 32'd0);
        serve(1'b0, 3'd0);
        check_eq("realloc_token", 32'(cap_tok), 32'b100);
        check_eq("realloc_park", 32'(cap_park), 32'd1);
        check_eq("realloc_occ", 32'(occupied), 32'hFF);

        // Exit of a free space is a no-op
        apply_reset();
        serve(1'b1, 3'b101);
        check_eq("free_exit_ok", 32'(cap_ok), 32'd0);
        check_eq("free_exit_occ", 32'(occupied), 32'h00);
        check_eq("free_exit_count", 32'(count), 32'd0);

        // Collisions: exit first after reset, then entry first
        apply_reset();
        serve(1'b0, 3'd0);
        ne = n_enter;
        nx = n_exit;
        exit_token = 3'b101;
        enter_req  = 1'b1;
        exit_req   = 1'b1;
        wait_ev(1'b1, lat);
        check_eq("coll1_exit_first", 32'(n_enter - ne), 32'd0);
        check_eq("coll1_lat", 32'(lat), 32'd3);
        check_eq("coll1_exit_ok", 32'(cap_ok), 32'd1);
        exit_req = 1'b0;
        wait_ev(1'b0, lat);
        check_eq("coll1_tok", 32'(cap_tok), 32'b101);
        check_eq("coll1_park", 32'(cap_park), 32'd0);
        enter_req = 1'b0;
        @(negedge clk);
        check_eq("coll1_occ", 32'(occupied), 32'h01);

        nx = n_exit;
        enter_req = 1'b1;
        exit_req  = 1'b1;
        wait_ev(1'b0, lat);
        check_eq("coll2_entry_first", 32'(n_exit - nx), 32'd0);
        check_eq("coll2_tok", 32'(cap_tok), 32'b100);
        check_eq("coll2_park", 32'(cap_park), 32'd1);
        enter_req = 1'b0;
        wait_ev(1'b1, lat);
        check_eq("coll2_exit_ok", 32'(cap_ok), 32'd1);
        exit_req = 1'b0;
        @(negedge clk);
        check_eq("coll2_occ", 32'(occupied), 32'h02);
        check_eq("coll2_count", 32'(count), 32'd1);

        // Held request acknowledged exactly once
        ne = n_enter;
        enter_req = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("held_once", 32'(n_enter - ne), 32'd1);
        enter_req = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("held_occ", 32'(occupied), 32'h03);

        // Pattern load accepted when empty
        apply_reset();
        pattern_load = 1'b1;
        pattern_in   = 3'b010;
        @(negedge clk);
        pattern_load = 1'b0;
        serve(1'b0, 3'd0);
        check_eq("pat_loaded_tok", 32'(cap_tok), 32'b010);

        // Pattern load ignored when a space is occupied
        apply_reset();
        serve(1'b0, 3'd0);
        check_eq("pat_default_tok", 32'(cap_tok), 32'b101);
        pattern_load = 1'b1;
        pattern_in   = 3'b010;
        @(negedge clk);
        pattern_load = 1'b0;
        serve(1'b0, 3'd0);
        check_eq("pat_ignored_tok", 32'(cap_tok), 32'b100);

        // Reset while in ENTRY_ACK
        apply_reset();
        enter_req = 1'b1;
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        enter_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ne = n_enter;
        repeat (4) @(negedge clk);
        check_eq("midack_no_ack", 32'(n_enter - ne), 32'd0);
        check_eq("midack_occ", 32'(occupied), 32'h00);
        check_eq("midack_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
